nes_pad_responder: RTL and testbench
====================================

NES_PAD_RESPONDER -- requirements
Module: nes_pad_responder

Interface
REQ-001 Parameter SYNC_STAGES, default 2: synchronizer depth on nes_latch and nes_pulse, legal range 2..3.
REQ-002 Parameter TIMEOUT_CYCLES, default 1_000_000: idle-pulse watchdog limit in clk cycles, which is 10 ms at 100 MHz.
REQ-003 Ports (one per line):
- clk, input, 1: 100 MHz system clock.
- sysreset_n, input, 1: asynchronous active-low reset.
- nes_latch, input, 1: asynchronous latch from the console/host.
- nes_pulse, input, 1: asynchronous shift clock from the console/host.
- buttons, input, 8: active-high button states; bit0=A, 1=B, 2=Select, 3=Start, 4=Up, 5=Down, 6=Left, 7=Right.
- nes_data, output, 1: serial data, active-low (0 = pressed).
- busy, output, 1: high while in LOAD or SHIFT.
- frame_done, output, 1: one-cycle pulse when the 8th bit has been shifted out.
- timeout, output, 1: one-cycle pulse on watchdog abort.

Function
REQ-004 nes_latch and nes_pulse SHALL each pass through a SYNC_STAGES flip-flop synchronizer; edge detection SHALL act only on the synchronized versions.
REQ-005 The FSM SHALL have exactly three states: IDLE, LOAD and SHIFT.
REQ-006 IDLE: nes_data=1 and bit_idx=0; a synchronized latch rising edge SHALL move the FSM to LOAD.
REQ-007 LOAD: the shift register SHALL reload from buttons every cycle while the latch is high; nes_data SHALL equal ~buttons[0].
REQ-008 LOAD: a synchronized latch falling edge SHALL freeze the snapshot and move the FSM to SHIFT with bit_idx=0.
REQ-009 SHIFT: each synchronized pulse rising edge SHALL increment bit_idx and drive nes_data=~snap[bit_idx], with the change registered on the cycle after the edge.
REQ-010 When bit_idx reaches 8: nes_data=0 (overflow value), frame_done pulses for one cycle, and the FSM stays in SHIFT until the next latch.
REQ-011 Latency from a pin edge to a nes_data change SHALL be SYNC_STAGES+1 clk cycles, no more and no less.
REQ-012 A latch rising edge in any state, including mid-frame, SHALL abort the frame and enter LOAD.
REQ-013 If a latch edge and a pulse edge occur in the same cycle, the latch SHALL win and the pulse SHALL be ignored.
REQ-014 Pulse edges in IDLE or LOAD SHALL be ignored.
REQ-015 Additional pulse edges after bit_idx=8 SHALL keep nes_data=0 and SHALL NOT re-assert frame_done.
REQ-016 Changes on buttons during SHIFT SHALL NOT affect the current frame.

Reset
REQ-017 While sysreset_n=0, the following SHALL be forced: FSM state=IDLE, nes_data=1, busy=0, frame_done=0, timeout=0, bit_idx=0, snapshot=8'h00, synchronizer flops=0, watchdog count=0.
REQ-018 Deassertion of sysreset_n SHALL take effect on the next clk edge with no spurious edge detected; synchronizer flops reset to 0, so a latch held high at release SHALL produce one rising edge and enter LOAD.

Configuration
REQ-019 Macro NES_RESP_TIMEOUT_EN defined: in SHIFT with bit_idx<8, a watchdog counter SHALL count cycles since the last pulse edge; reaching TIMEOUT_CYCLES SHALL pulse timeout and return the FSM to IDLE.
REQ-020 Macro NES_RESP_TIMEOUT_EN undefined: no watchdog logic SHALL be present, timeout SHALL be tied 0, and SHIFT SHALL persist until the next latch or reset.

Structure
REQ-021 Package nes_pkg SHALL hold the FSM state enum, the button index constants (BTN_A..BTN_RIGHT), NES_BITS=8 and NES_OVERFLOW_VAL=1'b0.
REQ-022 The synchronizer plus edge detect SHALL be sub-module nes_sync_edge (params: STAGES; outputs: level, rise, fall), instantiated twice.

Verification
REQ-023 With buttons=8'b0000_0101, latch held 12 us, then 8 pulses at 6 us period: nes_data sequence SHALL be 0,1,0,1,1,1,1,1, then 0 after pulse 8, with frame_done pulsing once.
REQ-024 Latch rising after 3 pulses with buttons=8'hFF: the FSM SHALL re-enter LOAD, nes_data SHALL be 0, and the next frame SHALL shift 8 zeros.
REQ-025 Latch edge and pulse edge in the same clk cycle: the pulse SHALL be ignored and bit_idx SHALL remain 0.
REQ-026 Buttons changed from 8'h01 to 8'h80 mid-SHIFT: the shifted frame SHALL still be 0,1,1,1,1,1,1,1.
REQ-027 sysreset_n asserted during SHIFT at bit_idx=4: nes_data=1 and busy=0 SHALL hold immediately, asynchronously.
REQ-028 With NES_RESP_TIMEOUT_EN defined and TIMEOUT_CYCLES=100, latch then no pulses: timeout SHALL pulse at cycle 100 after SHIFT entry, followed by IDLE with nes_data=1.

Source files
------------

// File: rtl/nes_pkg.sv
// Shared types and constants for the NES controller pad responder.
// State enum, button bit positions and frame constants.
package nes_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2
  } nes_state_t;

  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;

  localparam int   NES_BITS         = 8;
  localparam logic NES_OVERFLOW_VAL = 1'b0;

endpackage

// File: rtl/nes_sync_edge.sv
// Multi-flop synchronizer with registered-history edge detect.
// Flops reset to 0, so a high input at reset release yields one rise.
module nes_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign level = sync_q[STAGES-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;

endmodule

// File: rtl/nes_pad_responder.sv
// NES pad emulator: answers console latch/pulse with serial buttons.
// Optional idle-pulse watchdog enabled by NES_RESP_TIMEOUT_EN.
module nes_pad_responder
  import nes_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       sysreset_n,
  input  logic       nes_latch,
  input  logic       nes_pulse,
  input  logic [7:0] buttons,
  output logic       nes_data,
  output logic       busy,
  output logic       frame_done,
  output logic       timeout
);

  localparam logic [3:0] IDX_END = 4'(NES_BITS);

  nes_state_t state, state_d;
  logic [3:0] bit_idx, bit_idx_d;
  logic [3:0] idx_nx;
  logic [7:0] snap, snap_d;
  logic       nes_data_d;
  logic       frame_done_d;

  logic latch_level, latch_rise, latch_fall;
  logic pulse_level, pulse_rise, pulse_fall;
  logic pulse_unused;

  nes_sync_edge #(.STAGES(SYNC_STAGES)) u_latch_sync (
    .clk   (clk),
    .rst_n (sysreset_n),
    .d     (nes_latch),
    .level (latch_level),
    .rise  (latch_rise),
    .fall  (latch_fall)
  );

  nes_sync_edge #(.STAGES(SYNC_STAGES)) u_pulse_sync (
    .clk   (clk),
    .rst_n (sysreset_n),
    .d     (nes_pulse),
    .level (pulse_level),
    .rise  (pulse_rise),
    .fall  (pulse_fall)
  );

  assign pulse_unused = pulse_level ^ pulse_fall;

`ifdef NES_RESP_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  logic [WD_W-1:0] wd_cnt, wd_cnt_d;
  logic            timeout_d;
`endif

  always_comb begin
    state_d      = state;
    bit_idx_d    = bit_idx;
    snap_d       = snap;
    nes_data_d   = nes_data;
    frame_done_d = 1'b0;
    idx_nx       = bit_idx + 4'd1;
`ifdef NES_RESP_TIMEOUT_EN
    wd_cnt_d     = wd_cnt;
    timeout_d    = 1'b0;
`endif
    // Latch edge beats everything, including a coincident pulse edge.
    if (latch_rise) begin
      state_d    = ST_LOAD;
      bit_idx_d  = '0;
      snap_d     = buttons;
      nes_data_d = ~buttons[BTN_A];
`ifdef NES_RESP_TIMEOUT_EN
      wd_cnt_d   = '0;
`endif
    end else begin
      unique case (state)
        ST_IDLE: begin
          bit_idx_d  = '0;
          nes_data_d = 1'b1;
        end
        ST_LOAD: begin
          if (latch_fall) begin
            state_d    = ST_SHIFT;
            bit_idx_d  = '0;
            nes_data_d = ~snap[BTN_A];
`ifdef NES_RESP_TIMEOUT_EN
            wd_cnt_d   = '0;
`endif
          end else if (latch_level) begin
            snap_d     = buttons;
            nes_data_d = ~buttons[BTN_A];
          end
        end
        ST_SHIFT: begin
          if (pulse_rise && bit_idx < IDX_END) begin
            bit_idx_d = idx_nx;
`ifdef NES_RESP_TIMEOUT_EN
            wd_cnt_d  = '0;
`endif
            if (idx_nx == IDX_END) begin
              nes_data_d   = NES_OVERFLOW_VAL;
              frame_done_d = 1'b1;
            end else begin
              nes_data_d = ~snap[idx_nx[2:0]];
            end
          end else if (pulse_rise) begin
            nes_data_d = NES_OVERFLOW_VAL;
          end
`ifdef NES_RESP_TIMEOUT_EN
          else if (bit_idx < IDX_END) begin
            if (wd_cnt == WD_LAST) begin
              timeout_d  = 1'b1;
              state_d    = ST_IDLE;
              bit_idx_d  = '0;
              nes_data_d = 1'b1;
              wd_cnt_d   = '0;
            end else begin
              wd_cnt_d = wd_cnt + 1'b1;
            end
          end
`endif
        end
        default: begin
          state_d    = ST_IDLE;
          bit_idx_d  = '0;
          nes_data_d = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge sysreset_n) begin
    if (!sysreset_n) begin
      state      <= ST_IDLE;
      bit_idx    <= '0;
      snap       <= 8'h00;
      nes_data   <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      state      <= state_d;
      bit_idx    <= bit_idx_d;
      snap       <= snap_d;
      nes_data   <= nes_data_d;
      frame_done <= frame_done_d;
    end
  end

`ifdef NES_RESP_TIMEOUT_EN
  always_ff @(posedge clk or negedge sysreset_n) begin
    if (!sysreset_n) begin
      wd_cnt  <= '0;
      timeout <= 1'b0;
    end else begin
      wd_cnt  <= wd_cnt_d;
      timeout <= timeout_d;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_nes_pad_responder.sv
// Directed bench for nes_pad_responder: frame table plus corner sequences.
// Watchdog sequence depends on NES_RESP_TIMEOUT_EN.
module tb_nes_pad_responder;

  localparam int TO = 100;
`ifdef NES_RESP_TIMEOUT_EN
  localparam int H1 = 30;
`else
  localparam int H1 = 300;
`endif

  logic       clk = 1'b0;
  logic       sysreset_n;
  logic       nes_latch;
  logic       nes_pulse;
  logic [7:0] buttons;
  logic       nes_data;
  logic       busy;
  logic       frame_done;
  logic       timeout;

  int checks = 0;
  int errors = 0;
  int fd_cnt = 0;
  int to_cnt = 0;

  always #5 clk = ~clk;

  nes_pad_responder #(
    .SYNC_STAGES    (2),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk        (clk),
    .sysreset_n (sysreset_n),
    .nes_latch  (nes_latch),
    .nes_pulse  (nes_pulse),
    .buttons    (buttons),
    .nes_data   (nes_data),
    .busy       (busy),
    .frame_done (frame_done),
    .timeout    (timeout)
  );

  always @(negedge clk) begin
    if (frame_done === 1'b1) fd_cnt++;
    if (timeout === 1'b1) to_cnt++;
  end

  typedef struct {
    logic [7:0] btn;
    logic [7:0] btn_mid;
    logic [8:0] exp;
    int         hold;
    int         half;
  } vec_t;

  vec_t vecs[6];

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic pulse(input int h);
    nes_pulse = 1'b1;
    tick(h);
    nes_pulse = 1'b0;
    tick(h);
  endtask

  task automatic latch(input int h);
    nes_latch = 1'b1;
    tick(h);
    nes_latch = 1'b0;
    tick(h);
  endtask

  initial begin
    int fd0;
    vecs[0] = '{8'h05, 8'h05, 9'h0FA, 1200, H1};
    vecs[1] = '{8'hFF, 8'hFF, 9'h000, 10, 6};
    vecs[2] = '{8'h00, 8'h00, 9'h0FF, 10, 6};
    vecs[3] = '{8'h01, 8'h80, 9'h0FE, 10, 6};
    vecs[4] = '{8'hA5, 8'hA5, 9'h05A, 10, 6};
    vecs[5] = '{8'h80, 8'h80, 9'h07F, 10, 6};

    sysreset_n = 1'b0;
    nes_latch  = 1'b0;
    nes_pulse  = 1'b0;
    buttons    = 8'h00;
    tick(3);
    chk("rst_data", 32'(nes_data), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_fd", 32'(frame_done), 32'd0);
    chk("rst_to", 32'(timeout), 32'd0);

    // Latch already high at release must give one clean LOAD entry.
    buttons   = 8'h01;
    nes_latch = 1'b1;
    tick(1);
    sysreset_n = 1'b1;
    tick(2);
    chk("rel_busy_early", 32'(busy), 32'd0);
    chk("rel_data_early", 32'(nes_data), 32'd1);
    tick(1);
    chk("rel_busy", 32'(busy), 32'd1);
    chk("rel_data", 32'(nes_data), 32'd0);
    nes_latch = 1'b0;
    tick(6);
    chk("rel_shift0", 32'(nes_data), 32'd0);

    nes_pulse = 1'b1;
    tick(2);
    chk("lat_pulse_early", 32'(nes_data), 32'd0);
    tick(1);
    chk("lat_pulse", 32'(nes_data), 32'd1);
    nes_pulse = 1'b0;
    tick(6);

    for (int v = 0; v < 6; v++) begin
      buttons   = vecs[v].btn;
      nes_latch = 1'b1;
      tick(vecs[v].hold);
      chk($sformatf("v%0d_load_busy", v), 32'(busy), 32'd1);
      chk($sformatf("v%0d_load", v), 32'(nes_data),
          32'(vecs[v].exp[0]));
      nes_latch = 1'b0;
      tick(vecs[v].hold);
      chk($sformatf("v%0d_bit0", v), 32'(nes_data),
          32'(vecs[v].exp[0]));
      fd0 = fd_cnt;
      for (int p = 1; p <= 8; p++) begin
        if (p == 4) buttons = vecs[v].btn_mid;
        pulse(vecs[v].half);
        chk($sformatf("v%0d_p%0d", v, p), 32'(nes_data),
            32'(vecs[v].exp[p]));
      end
      chk($sformatf("v%0d_fd", v), 32'(fd_cnt - fd0), 32'd1);
      pulse(vecs[v].half);
      chk($sformatf("v%0d_extra", v), 32'(nes_data), 32'd0);
      chk($sformatf("v%0d_extra_fd", v), 32'(fd_cnt - fd0), 32'd1);
      chk($sformatf("v%0d_busy", v), 32'(busy), 32'd1);
    end

    // Abort a frame mid-shift with a fresh latch.
    buttons   = 8'h00;
    nes_latch = 1'b1;
    tick(8);
    nes_latch = 1'b0;
    tick(8);
    for (int p = 0; p < 3; p++) pulse(6);
    chk("abort_pre", 32'(nes_data), 32'd1);
    buttons   = 8'hFF;
    nes_latch = 1'b1;
    tick(2);
    chk("abort_early", 32'(nes_data), 32'd1);
    tick(1);
    chk("abort_data", 32'(nes_data), 32'd0);
    chk("abort_busy", 32'(busy), 32'd1);
    tick(5);
    nes_latch = 1'b0;
    tick(8);
    fd0 = fd_cnt;
    for (int p = 1; p <= 8; p++) begin
      pulse(6);
      chk($sformatf("abort_p%0d", p), 32'(nes_data), 32'd0);
    end
    chk("abort_fd", 32'(fd_cnt - fd0), 32'd1);

    // Coincident latch and pulse edges: pulse must be dropped.
    buttons = 8'h02;
    latch(8);
    chk("same_pre", 32'(nes_data), 32'd1);
    nes_latch = 1'b1;
    nes_pulse = 1'b1;
    tick(8);
    chk("same_load", 32'(nes_data), 32'd1);
    nes_latch = 1'b0;
    tick(8);
    chk("same_idx0", 32'(nes_data), 32'd1);
    nes_pulse = 1'b0;
    tick(8);
    pulse(6);
    chk("same_bit1", 32'(nes_data), 32'd0);
    pulse(6);
    chk("same_bit2", 32'(nes_data), 32'd1);

`ifdef NES_RESP_TIMEOUT_EN
    buttons = 8'h00;
    nes_latch = 1'b1;
    tick(8);
    nes_latch = 1'b0;
    tick(TO + 2);
    chk("wd_early", 32'(timeout), 32'd0);
    chk("wd_busy_early", 32'(busy), 32'd1);
    tick(1);
    chk("wd_pulse", 32'(timeout), 32'd1);
    tick(1);
    chk("wd_clear", 32'(timeout), 32'd0);
    chk("wd_idle_busy", 32'(busy), 32'd0);
    chk("wd_idle_data", 32'(nes_data), 32'd1);
    chk("wd_count", 32'(to_cnt), 32'd1);
`else
    tick(3 * TO);
    chk("nowd_busy", 32'(busy), 32'd1);
    chk("nowd_data", 32'(nes_data), 32'd1);
    chk("nowd_to", 32'(to_cnt), 32'd0);
`endif

    // Asynchronous reset at bit 4 of a frame.
    buttons = 8'hFF;
    latch(8);
    for (int p = 0; p < 4; p++) pulse(6);
    chk("arst_pre_data", 32'(nes_data), 32'd0);
    chk("arst_pre_busy", 32'(busy), 32'd1);
    #2;
    sysreset_n = 1'b0;
    #1;
    chk("arst_data", 32'(nes_data), 32'd1);
    chk("arst_busy", 32'(busy), 32'd0);
    tick(2);
    sysreset_n = 1'b1;
    tick(4);
    chk("arst_after", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
